// File: rtl/multibyte_alu_seq_if.sv
// Request/result and ALU-side signal bundle for the multi-byte ALU sequencer.
// The master side both issues requests and hosts the shared 8-bit ALU.
interface multibyte_alu_seq_if #(
   parameter int BYTES = 4
);
   localparam int W = 8 * BYTES;

   logic         start;
   logic [2:0]   cmd;
   logic         cin;
   logic [W-1:0] opa;
   logic [W-1:0] opb;
   logic         hold;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         flag_c;
   logic         flag_z;
   logic         flag_n;
   logic         flag_v;
   logic [3:0]   alu_op;
   logic         alu_right;
   logic [7:0]   alu_ai;
   logic [7:0]   alu_bi;
   logic         alu_ci;
   logic         alu_bcd;
   logic         alu_rdy;
   logic [7:0]   alu_out;
   logic         alu_co;
   logic         alu_v;
   logic         alu_z;
   logic         alu_n;

   modport master (
      output start, cmd, cin, opa, opb, hold, alu_out, alu_co, alu_v, alu_z, alu_n,
      input  busy, done, result, flag_c, flag_z, flag_n, flag_v,
             alu_op, alu_right, alu_ai, alu_bi, alu_ci, alu_bcd, alu_rdy
   );

   modport slave (
      input  start, cmd, cin, opa, opb, hold, alu_out, alu_co, alu_v, alu_z, alu_n,
      output busy, done, result, flag_c, flag_z, flag_n, flag_v,
             alu_op, alu_right, alu_ai, alu_bi, alu_ci, alu_bcd, alu_rdy
   );
endinterface

// File: rtl/multibyte_alu_seq.sv
// Runs one BYTES-wide operation through a shared registered 8-bit ALU, one byte
// per issue/capture pair, chaining carry LSB-first (MSB-first for rotate-right).
module multibyte_alu_seq #(
   parameter int BYTES = 4
) (
   input  logic               clk,
   input  logic               reset_n,
   multibyte_alu_seq_if.slave bus
);
   localparam int W  = 8 * BYTES;
   localparam int IW = $clog2(BYTES);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_FINISH} state_e;
   typedef enum logic [2:0] {C_ADD, C_SUB, C_ROL, C_ROR, C_AND, C_OR, C_XOR, C_PASS} cmd_e;

   state_e        r_state, w_state_next;
   cmd_e          r_cmd, w_cmd_in;
   logic [W-1:0]  r_a, r_b, r_acc, r_result, w_acc_next;
   logic [IW-1:0] r_idx;
   logic          r_carry, r_zero, r_done;
   logic          r_flag_c, r_flag_z, r_flag_n, r_flag_v;
   logic          w_accept, w_capture, w_rdy, w_last, w_active;
   logic          w_chained, w_chained_in, w_use_b, w_arith;
   logic          w_unused_n;

   function automatic logic [3:0] alu_op_of(input cmd_e c);
      case (c)
         C_ADD:   alu_op_of = 4'b0011;
         C_SUB:   alu_op_of = 4'b0111;
         C_ROL:   alu_op_of = 4'b1011;
         C_ROR:   alu_op_of = 4'b1111;
         C_OR:    alu_op_of = 4'b1100;
         C_AND:   alu_op_of = 4'b1101;
         C_XOR:   alu_op_of = 4'b1110;
         default: alu_op_of = 4'b1111;
      endcase
   endfunction

   assign w_cmd_in     = cmd_e'(bus.cmd);
   assign w_chained_in = w_cmd_in inside {C_ADD, C_SUB, C_ROL, C_ROR};
   assign w_chained    = r_cmd inside {C_ADD, C_SUB, C_ROL, C_ROR};
   assign w_arith      = r_cmd inside {C_ADD, C_SUB};
   assign w_use_b      = r_cmd inside {C_ADD, C_SUB, C_AND, C_OR, C_XOR};
   assign w_last       = (r_cmd == C_ROR) ? (r_idx == '0) : (r_idx == IW'(BYTES - 1));
   assign w_active     = (r_state == S_ISSUE) || (r_state == S_CAPTURE);
   assign w_unused_n   = bus.alu_n;

   // Working copy with the byte currently on alu_out merged in.
   always_comb begin
      w_acc_next = r_acc;
      w_acc_next[8*r_idx +: 8] = bus.alu_out;
   end

   // ALU inputs only change when the state/index registers do, so hold freezes them.
   assign bus.alu_op    = w_active ? alu_op_of(r_cmd) : 4'd0;
   assign bus.alu_right = w_active && (r_cmd == C_ROR);
   assign bus.alu_ai    = w_active ? r_a[8*r_idx +: 8] : 8'd0;
   assign bus.alu_bi    = (w_active && w_use_b) ? r_b[8*r_idx +: 8] : 8'd0;
   assign bus.alu_ci    = w_active && r_carry;
   assign bus.alu_bcd   = 1'b0;
   assign bus.alu_rdy   = w_rdy;

   assign bus.busy   = (r_state != S_IDLE);
   assign bus.done   = r_done;
   assign bus.result = r_result;
   assign bus.flag_c = r_flag_c;
   assign bus.flag_z = r_flag_z;
   assign bus.flag_n = r_flag_n;
   assign bus.flag_v = r_flag_v;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_next;
   end

   always_comb begin
      // NOTE: every signal gets a default before the case so no path infers a latch.
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_capture    = 1'b0;
      w_rdy        = 1'b0;
      case (r_state)
         S_IDLE: if (bus.start && !bus.hold) begin
            w_accept     = 1'b1;
            w_state_next = S_ISSUE;
         end
         S_ISSUE: if (!bus.hold) begin
            w_rdy        = 1'b1;
            w_state_next = S_CAPTURE;
         end
         S_CAPTURE: if (!bus.hold) begin
            w_capture    = 1'b1;
            w_state_next = w_last ? S_FINISH : S_ISSUE;
         end
         S_FINISH: w_state_next = S_IDLE;
         default:  w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cmd    <= C_ADD;
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_result <= '0;
         r_idx    <= '0;
         r_carry  <= 1'b0;
         r_zero   <= 1'b0;
         r_done   <= 1'b0;
         r_flag_c <= 1'b0;
         r_flag_z <= 1'b0;
         r_flag_n <= 1'b0;
         r_flag_v <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values of the others.
         r_done <= 1'b0;
         if (w_accept) begin
            r_cmd   <= w_cmd_in;
            r_a     <= bus.opa;
            r_b     <= bus.opb;
            r_acc   <= '0;
            r_idx   <= (w_cmd_in == C_ROR) ? IW'(BYTES - 1) : '0;
            r_carry <= w_chained_in & bus.cin;
            r_zero  <= 1'b1;
         end
         if (w_capture) begin
            r_acc   <= w_acc_next;
            r_carry <= w_chained & bus.alu_co;
            r_zero  <= r_zero & bus.alu_z;
            r_idx   <= (r_cmd == C_ROR) ? r_idx - 1'b1 : r_idx + 1'b1;
            // Result and flags publish together with the done pulse.
            if (w_last) begin
               r_result <= w_acc_next;
               r_flag_c <= w_chained & bus.alu_co;
               r_flag_v <= w_arith & bus.alu_v;
               r_flag_z <= r_zero & bus.alu_z;
               r_flag_n <= w_acc_next[W-1];
               r_done   <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_multibyte_alu_seq.sv
// Bench for multibyte_alu_seq: hosts a behavioural 8-bit ALU and checks every
// multi-byte result against whole-word arithmetic.
module tb_multibyte_alu_seq;
   localparam int BYTES = 4;
   localparam int W     = 8 * BYTES;
   localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_ROL = 3'd2, OP_ROR = 3'd3,
                          OP_AND = 3'd4, OP_OR  = 3'd5, OP_XOR = 3'd6, OP_PASS = 3'd7;

   typedef struct packed {logic [W-1:0] r; logic c, z, n, v;} res_t;
   typedef struct packed {logic [7:0] o; logic co, v;} alu_res_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [7:0] ai_q[$];
   alu_res_t   alu_now;

   multibyte_alu_seq_if #(.BYTES(BYTES)) bus ();
   multibyte_alu_seq #(.BYTES(BYTES)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   always #5 clk = ~clk;

   // 6502-style byte ALU, registered on RDY.
   function automatic alu_res_t alu_byte(input logic [3:0] op, input logic right,
                                         input logic [7:0] ai, input logic [7:0] bi, input logic ci);
      alu_res_t a;
      logic [8:0] s;
      logic [7:0] bn;
      a  = '0;
      bn = (op == 4'b0111) ? ~bi : bi;
      if (right) begin
         a.o  = {ci, ai[7:1]};
         a.co = ai[0];
      end else begin
         case (op)
            4'b0011, 4'b0111: begin
               s    = {1'b0, ai} + {1'b0, bn} + {8'd0, ci};
               a.o  = s[7:0];
               a.co = s[8];
               a.v  = (ai[7] == bn[7]) && (s[7] != ai[7]);
            end
            4'b1011: begin
               s    = {1'b0, ai} + {1'b0, ai} + {8'd0, ci};
               a.o  = s[7:0];
               a.co = s[8];
            end
            4'b1100: a.o = ai | bi;
            4'b1101: a.o = ai & bi;
            4'b1110: a.o = ai ^ bi;
            default: a.o = ai;
         endcase
      end
      return a;
   endfunction

   always @(posedge clk) begin
      if (!reset_n) begin
         bus.alu_out <= 8'd0;
         bus.alu_co  <= 1'b0;
         bus.alu_v   <= 1'b0;
         bus.alu_z   <= 1'b0;
         bus.alu_n   <= 1'b0;
      end else if (bus.alu_rdy) begin
         alu_now = alu_byte(bus.alu_op, bus.alu_right, bus.alu_ai, bus.alu_bi, bus.alu_ci);
         bus.alu_out <= alu_now.o;
         bus.alu_co  <= alu_now.co;
         bus.alu_v   <= alu_now.v;
         bus.alu_z   <= (alu_now.o == 8'd0);
         bus.alu_n   <= alu_now.o[7];
         ai_q.push_back(bus.alu_ai);
      end
   end

   // Whole-word reference model.
   function automatic res_t ref_op(input logic [2:0] c, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic ci);
      res_t m;
      logic [W:0] s;
      m = '0;
      case (c)
         OP_ADD: begin
            s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
            m.r = s[W-1:0]; m.c = s[W];
            m.v = (a[W-1] == b[W-1]) && (m.r[W-1] != a[W-1]);
         end
         OP_SUB: begin
            s = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, ci};
            m.r = s[W-1:0]; m.c = s[W];
            m.v = (a[W-1] != b[W-1]) && (m.r[W-1] != a[W-1]);
         end
         OP_ROL: begin m.r = {a[W-2:0], ci}; m.c = a[W-1]; end
         OP_ROR: begin m.r = {ci, a[W-1:1]}; m.c = a[0]; end
         OP_AND: m.r = a & b;
         OP_OR:  m.r = a | b;
         OP_XOR: m.r = a ^ b;
         default: m.r = a;
      endcase
      m.z = (m.r == '0);
      m.n = m.r[W-1];
      return m;
   endfunction

   // Issues one request starting at a negedge; returns at the negedge of the cycle after done.
   task automatic run_op(input logic [2:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input int hold_at, input int hold_len, input int poke_at,
                         output int lat, output res_t got, output logic quiet_ok, output logic after_ok);
      logic [W-1:0] prev;
      prev     = bus.result;
      quiet_ok = 1'b1;
      lat      = -1;
      got      = '0;
      ai_q.delete();
      bus.cmd = c; bus.opa = a; bus.opb = b; bus.cin = ci; bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      bus.cmd = ~c; bus.opa = ~a; bus.opb = $urandom; bus.cin = ~ci;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         if (bus.done === 1'b1) begin
            lat = cyc;
            got = {bus.result, bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v};
            break;
         end
         if (bus.result !== prev || bus.busy !== 1'b1) quiet_ok = 1'b0;
         bus.hold  = (cyc >= hold_at) && (cyc < hold_at + hold_len);
         bus.start = (cyc == poke_at);
         #1;
         if (bus.hold && bus.alu_rdy !== 1'b0) quiet_ok = 1'b0;
         @(negedge clk);
      end
      bus.hold  = 1'b0;
      bus.start = 1'b0;
      @(negedge clk);
      after_ok = (bus.done === 1'b0) && (bus.busy === 1'b0);
   endtask

   task automatic test_reset();
      logic [W+35:0] outs;
      repeat (2) @(negedge clk);
      outs = {bus.busy, bus.done, bus.result, bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v,
              bus.alu_op, bus.alu_right, bus.alu_ai, bus.alu_bi, bus.alu_ci, bus.alu_bcd, bus.alu_rdy};
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL reset_outputs got %h expected 0", outs);
      end
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle busy=%b done=%b expected 0 0", bus.busy, bus.done);
      end
   endtask

   task automatic test_directed();
      logic [2:0]   vc [6]   = '{OP_ADD, OP_SUB, OP_ADD, OP_ROL, OP_ROR, OP_XOR};
      logic [W-1:0] va [6]   = '{32'h00FFFFFF, 32'h00000000, 32'h7FFFFFFF, 32'h80000000, 32'h00000001, 32'hA5A5A5A5};
      logic [W-1:0] vb [6]   = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h12345678, 32'h9ABCDEF0, 32'hA5A5A5A5};
      logic         vci [6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      res_t         vexp [6] = '{{32'h01000000, 4'b0000}, {32'hFFFFFFFF, 4'b0010}, {32'h80000000, 4'b0011},
                                 {32'h00000000, 4'b1100}, {32'h80000000, 4'b1010}, {32'h00000000, 4'b0100}};
      int lat; res_t got; logic qok, aok;
      for (int i = 0; i < 6; i++) begin
         run_op(vc[i], va[i], vb[i], vci[i], 0, 0, 0, lat, got, qok, aok);
         checks++;
         if (got !== vexp[i]) begin
            errors++;
            $display("FAIL directed_%0d result/czn v got %h expected %h", i, got, vexp[i]);
         end
         checks++;
         if (lat !== 2 * BYTES + 1) begin
            errors++;
            $display("FAIL directed_%0d latency got %0d expected %0d", i, lat, 2 * BYTES + 1);
         end
         checks++;
         if (qok !== 1'b1 || aok !== 1'b1) begin
            errors++;
            $display("FAIL directed_%0d busy/hidden/done-pulse got %b%b expected 11", i, qok, aok);
         end
      end
   endtask

   task automatic test_ror_order();
      logic [W-1:0] a; logic [7:0] exp_q[$]; logic ok;
      int lat; res_t got; logic qok, aok;
      for (int k = 0; k < 2; k++) begin
         a = $urandom;
         exp_q.delete();
         if (k == 0) for (int i = BYTES - 1; i >= 0; i--) exp_q.push_back(a[8*i +: 8]);
         else        for (int i = 0; i < BYTES; i++)      exp_q.push_back(a[8*i +: 8]);
         run_op((k == 0) ? OP_ROR : OP_ADD, a, 32'h01010101, 1'b1, 0, 0, 0, lat, got, qok, aok);
         ok = (ai_q.size() == exp_q.size());
         for (int i = 0; i < exp_q.size() && ok; i++) if (ai_q[i] !== exp_q[i]) ok = 1'b0;
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL byte_order_%s got %p expected %p", (k == 0) ? "ror" : "add", ai_q, exp_q);
         end
      end
   endtask

   task automatic test_random();
      logic [2:0] c; logic [W-1:0] a, b; logic ci; res_t exp;
      int lat; res_t got; logic qok, aok;
      for (int i = 0; i < 40; i++) begin
         c = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom; ci = 1'($urandom);
         if ($urandom_range(0, 3) == 0) b = a;
         if ($urandom_range(0, 5) == 0) a = '0;
         exp = ref_op(c, a, b, ci);
         run_op(c, a, b, ci, 0, 0, 0, lat, got, qok, aok);
         checks++;
         if (got !== exp || lat !== 2 * BYTES + 1 || !qok || !aok) begin
            errors++;
            $display("FAIL random_%0d cmd=%0d a=%h b=%h ci=%b got %h lat %0d expected %h lat %0d",
                     i, c, a, b, ci, got, lat, exp, 2 * BYTES + 1);
         end
      end
   endtask

   task automatic test_hold();
      int hat [2] = '{3, 2};
      int hlen [2] = '{3, 1};
      logic [W-1:0] a, b; int lat; res_t got, exp; logic qok, aok;
      for (int i = 0; i < 2; i++) begin
         a = $urandom; b = $urandom;
         exp = ref_op(OP_ADD, a, b, 1'b1);
         run_op(OP_ADD, a, b, 1'b1, hat[i], hlen[i], 0, lat, got, qok, aok);
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL hold_%0d result got %h expected %h", i, got, exp);
         end
         checks++;
         if (lat !== 2 * BYTES + 1 + hlen[i] || !qok) begin
            errors++;
            $display("FAIL hold_%0d latency/rdy got %0d/%b expected %0d/1", i, lat, qok, 2 * BYTES + 1 + hlen[i]);
         end
      end
   endtask

   task automatic test_ignore_start();
      logic [W-1:0] a, b; int lat; res_t got, exp; logic qok, aok, idle_ok;
      a = $urandom; b = $urandom;
      exp = ref_op(OP_SUB, a, b, 1'b0);
      run_op(OP_SUB, a, b, 1'b0, 0, 0, 4, lat, got, qok, aok);
      checks++;
      if (got !== exp || lat !== 2 * BYTES + 1 || !aok) begin
         errors++;
         $display("FAIL start_while_busy got %h lat %0d expected %h lat %0d", got, lat, exp, 2 * BYTES + 1);
      end
      idle_ok = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) idle_ok = 1'b0;
      end
      checks++;
      if (!idle_ok) begin
         errors++;
         $display("FAIL start_while_busy_spurious_op got activity expected idle");
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] c; logic [W-1:0] a, b; int lat; res_t got, exp; logic qok, aok;
      for (int i = 0; i < 3; i++) begin
         c = 3'(i * 3); a = $urandom; b = $urandom;
         exp = ref_op(c, a, b, 1'b1);
         run_op(c, a, b, 1'b1, 0, 0, 0, lat, got, qok, aok);
         checks++;
         if (got !== exp || lat !== 2 * BYTES + 1 || !qok) begin
            errors++;
            $display("FAIL back_to_back_%0d got %h lat %0d expected %h lat %0d", i, got, lat, exp, 2 * BYTES + 1);
         end
      end
   endtask

   task automatic test_reset_mid_op();
      logic [W+35:0] outs; logic idle_ok; int lat; res_t got, exp; logic qok, aok;
      run_op(OP_PASS, 32'hDEADBEEF, 32'h0, 1'b0, 0, 0, 0, lat, got, qok, aok);
      checks++;
      if (got.r !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL pass_before_reset got %h expected deadbeef", got.r);
      end
      bus.cmd = OP_ADD; bus.opa = 32'h11111111; bus.opb = 32'h22222222; bus.cin = 1'b0; bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      reset_n = 1'b0;
      #1;
      outs = {bus.busy, bus.done, bus.result, bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v,
              bus.alu_op, bus.alu_right, bus.alu_ai, bus.alu_bi, bus.alu_ci, bus.alu_bcd, bus.alu_rdy};
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("FAIL reset_mid_op_outputs got %h expected 0", outs);
      end
      @(negedge clk);
      reset_n = 1'b1;
      idle_ok = 1'b1;
      repeat (15) begin
         @(negedge clk);
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) idle_ok = 1'b0;
      end
      checks++;
      if (!idle_ok) begin
         errors++;
         $display("FAIL reset_mid_op_no_done got activity expected idle");
      end
      exp = ref_op(OP_ROL, 32'hC0FFEE01, 32'h0, 1'b1);
      run_op(OP_ROL, 32'hC0FFEE01, 32'h0, 1'b1, 0, 0, 0, lat, got, qok, aok);
      checks++;
      if (got !== exp || lat !== 2 * BYTES + 1) begin
         errors++;
         $display("FAIL after_reset_op got %h lat %0d expected %h lat %0d", got, lat, exp, 2 * BYTES + 1);
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.cmd = 3'd0; bus.cin = 1'b0;
      bus.opa = '0; bus.opb = '0; bus.hold = 1'b0;
      test_reset();
      test_directed();
      test_ror_order();
      test_random();
      test_hold();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid_op();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/multibyte_alu_seq.md
Name: multibyte_alu_seq

Overview:
- Sequences the shared 8-bit 6502-style ALU to run one multi-byte (BYTES×8-bit) operation per request.
- Issues one byte per ALU pass and chains carry between passes: LSB-first for add/sub/rotate-left, MSB-first for rotate-right.
- Sits beside the CPU-side ALU instance and serves the vector/math helper logic that needs 16/32-bit arithmetic without a second adder.

Parameters:
- BYTES, 4, operand width in bytes (2..8); W = 8*BYTES.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- cmd  in  3  operation: 0 ADD, 1 SUB, 2 ROL, 3 ROR, 4 AND, 5 OR, 6 XOR, 7 PASS.
- cin  in  1  carry in (ADD/ROL/ROR), not-borrow (SUB); ignored for logic ops.
- opa  in  W  operand A, latched at start.
- opb  in  W  operand B, latched at start.
- hold  in  1  stall: freezes sequencer and drives alu_rdy low.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when result/flags valid.
- result  out  W  result, held until next done.
- flag_c  out  1  final carry (ADD/SUB/ROL/ROR), else 0.
- flag_z  out  1  1 when all result bytes are zero.
- flag_n  out  1  result[W-1].
- flag_v  out  1  signed overflow of top byte (ADD/SUB only), else 0.
- alu_op  out  4  ALU operation code.
- alu_right  out  1  ALU right-shift select.
- alu_ai  out  8  ALU A byte.
- alu_bi  out  8  ALU B byte.
- alu_ci  out  1  ALU carry in.
- alu_bcd  out  1  tied 0.
- alu_rdy  out  1  ALU register enable.
- alu_out  in  8  registered ALU result.
- alu_co, alu_v, alu_z, alu_n  in  1  ALU flags (valid the cycle after a RDY edge).

Behaviour:
- Reset: IDLE; busy, done, flag_* = 0; result = 0; alu_* outputs = 0. Reset mid-operation aborts with no done pulse and discards latched operands.
- cmd→ALU mapping: ADD 0011; SUB 0111; ROL 1011, right=0; ROR 1111, right=1; OR 1100; AND 1101; XOR 1110; PASS 1111. alu_bi = B byte for ADD/SUB/logic, 0 otherwise.
- FSM states: IDLE → ISSUE → CAPTURE → (ISSUE | FINISH) → IDLE.
- IDLE: if start, latch opa/opb/cmd/cin, set byte index (0 for LSB-first; BYTES-1 for ROR), busy=1, go to ISSUE. start while busy is ignored.
- ISSUE: drive alu_ai/bi/op/right, drive alu_ci, assert alu_rdy=1, go to CAPTURE.
  - alu_ci on first byte = cin for ADD/SUB/ROL/ROR, 0 for logic ops.
  - alu_ci on later bytes = carry captured from the previous byte.
- CAPTURE: alu_rdy=0.
  - Write alu_out into the result byte at the index.
  - Save alu_co as the chain carry.
  - AND alu_z into the running zero flag.
  - If this is the last byte, go to FINISH; else step the index and go to ISSUE.
- FINISH:
  - Update result and flags together.
  - flag_c = last alu_co for chained ops, else 0.
  - flag_v = alu_v from byte BYTES-1 for ADD/SUB, else 0.
  - flag_n = result MSB.
  - Pulse done, clear busy, go to IDLE.
- Latency: start accepted at edge 0; done high in cycle 2*BYTES+1 (9 for BYTES=4). Back-to-back start is allowed the cycle after done.
- hold=1: state, index and alu_* inputs are frozen and alu_rdy=0. No ISSUE is consumed while held. A hold during CAPTURE delays the capture without losing data, since the ALU output register is stable while RDY is low.
- ALU ROR byte behaviour: out = {CI, AI[7:1]}, CO = AI[0]. Chaining MSB-first therefore gives a W-bit rotate through carry.
- ALU ROL byte behaviour: AI+AI+CI. LSB-first chaining gives a W-bit rotate-left through carry.
- Intermediate result bytes are not visible on result before done.

Test Plan:
- BYTES=4, ADD opa=0x00FFFFFF, opb=0x00000001, cin=0 → result 0x01000000, C=0, Z=0, N=0, V=0; done 9 cycles after start.
- SUB opa=0x00000000, opb=0x00000001, cin=1 → result 0xFFFFFFFF, C=0, N=1, V=0.
- ADD 0x7FFFFFFF+0x00000001, cin=0 → 0x80000000, V=1, N=1; ROL 0x80000000, cin=0 → 0x00000000, C=1, Z=1.
- ROR 0x00000001, cin=1 → 0x80000000, C=1. ROR trace must show bytes issued in order 3,2,1,0.
- XOR 0xA5A5A5A5^0xA5A5A5A5 → 0, Z=1, C=0, V=0 with cin=1.
- hold asserted 3 cycles in mid-ADD → result identical, done delayed by exactly 3. Second start while busy → ignored. reset_n low mid-op → no done, outputs 0, next start runs correctly.
